// File: rtl/hazard_ctrl_unit.sv
// Pipeline hazard control: operand forwarding, load-use stall, branch flush and a
// multi-cycle multiply hold FSM. Define HAZARD_PERF_CNT_EN to build the stall/flush counters.
module hazard_ctrl_unit #(
    parameter int REG_ADDR_W = 5,
    parameter int MUL_LAT    = 3,
    parameter int CNT_W      = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  RegWriteM,
    input  logic                  RegWriteW,
    input  logic [REG_ADDR_W-1:0] RD_M,
    input  logic [REG_ADDR_W-1:0] RD_W,
    input  logic [REG_ADDR_W-1:0] Rs1_E,
    input  logic [REG_ADDR_W-1:0] Rs2_E,
    input  logic [REG_ADDR_W-1:0] Rs1_D,
    input  logic [REG_ADDR_W-1:0] Rs2_D,
    input  logic [REG_ADDR_W-1:0] RD_E,
    input  logic                  ResultSrcE,
    input  logic                  PCSrcE,
    input  logic                  MulStartE,
    output logic [1:0]            ForwardAE,
    output logic [1:0]            ForwardBE,
    output logic                  StallF,
    output logic                  StallD,
    output logic                  StallE,
    output logic                  FlushD,
    output logic                  FlushE,
    output logic                  FlushM,
    output logic                  MulBusy,
    output logic [CNT_W-1:0]      StallCount,
    output logic [CNT_W-1:0]      FlushCount
);

    typedef enum logic {
        IDLE,
        MUL_BUSY
    } state_t;

    // The start cycle itself counts as one of the MUL_LAT execute cycles.
    localparam bit       MUL_MULTI = (MUL_LAT > 1);
    localparam logic [3:0] MUL_LOAD = (MUL_LAT > 1) ? 4'(MUL_LAT - 2) : 4'd0;

    state_t     state_reg, state_next;
    logic [3:0] cnt_reg, cnt_next;
    logic       lw_stall;

    logic [1:0][REG_ADDR_W-1:0] rs_e;
    logic [1:0][1:0]            fwd_sel;

    assign rs_e = {Rs2_E, Rs1_E};

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_fwd
            assign fwd_sel[gi] =
                (!rst)                                                        ? 2'b00 :
                (RegWriteM && (RD_M != '0) && (RD_M == rs_e[gi]))             ? 2'b10 :
                (RegWriteW && (RD_W != '0) && (RD_W == rs_e[gi]))             ? 2'b01 :
                                                                                2'b00;
        end
    endgenerate

    assign ForwardAE = fwd_sel[0];
    assign ForwardBE = fwd_sel[1];

    assign lw_stall = ResultSrcE && (RD_E != '0) && ((RD_E == Rs1_D) || (RD_E == Rs2_D));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg <= IDLE;
            cnt_reg   <= 4'd0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        StallF     = 1'b0;
        StallD     = 1'b0;
        StallE     = 1'b0;
        FlushD     = 1'b0;
        FlushE     = 1'b0;
        FlushM     = 1'b0;
        MulBusy    = 1'b0;
        // Holding reset keeps every control output quiet regardless of inputs.
        if (rst) begin
            case (state_reg)
                IDLE: begin
                    StallF = lw_stall && !PCSrcE;
                    StallD = lw_stall && !PCSrcE;
                    FlushD = PCSrcE;
                    FlushE = lw_stall || PCSrcE;
                    if (MulStartE && !PCSrcE && MUL_MULTI) begin
                        state_next = MUL_BUSY;
                        cnt_next   = MUL_LOAD;
                    end
                end
                MUL_BUSY: begin
                    // Load-use and redirect are masked; the multiply owns E.
                    MulBusy = 1'b1;
                    StallF  = 1'b1;
                    StallD  = 1'b1;
                    StallE  = 1'b1;
                    FlushM  = 1'b1;
                    if (cnt_reg == 4'd0) begin
                        state_next = IDLE;
                    end else begin
                        cnt_next = cnt_reg - 4'd1;
                    end
                end
                default: begin
                    state_next = IDLE;
                    cnt_next   = 4'd0;
                end
            endcase
        end
    end

`ifdef HAZARD_PERF_CNT_EN
    logic [CNT_W-1:0] stall_cnt_reg;
    logic [CNT_W-1:0] flush_cnt_reg;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stall_cnt_reg <= '0;
            flush_cnt_reg <= '0;
        end else begin
            if (StallF && (stall_cnt_reg != '1)) begin
                stall_cnt_reg <= stall_cnt_reg + CNT_W'(1);
            end
            if ((FlushE || FlushM) && (flush_cnt_reg != '1)) begin
                flush_cnt_reg <= flush_cnt_reg + CNT_W'(1);
            end
        end
    end

    assign StallCount = stall_cnt_reg;
    assign FlushCount = flush_cnt_reg;
`else
    assign StallCount = '0;
    assign FlushCount = '0;
`endif

endmodule
